// File: rtl/imem_uart_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader:
// FSM encodings, the frame header byte and the default bit period.
package imem_uart_loader_pkg;

  localparam int unsigned CLK_DIV_DEFAULT = 868;
  localparam logic [7:0]  HDR_BYTE        = 8'hA5;

  typedef enum logic [2:0] {
    ST_HDR, ST_CNT_LO, ST_CNT_HI, ST_DATA, ST_DONE, ST_ERR
  } loader_state_e;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_e;

  typedef struct packed {
    loader_state_e loader;
    rx_state_e     rx;
  } dbg_t;

endpackage

// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write port. imem_we is a one-cycle strobe with no back-pressure
// (the memory always accepts); imem_addr/imem_wdata are valid while imem_we is high.
interface imem_uart_loader_if #(parameter int AW = 11);
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  modport master (output imem_we, output imem_addr, output imem_wdata);
  modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/imem_uart_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, start-bit validation at half a bit
// period, mid-bit sampling, one-cycle byte_valid / framing_err pulses.
module uart_rx
  import imem_uart_loader_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       framing_err,
  output rx_state_e  state_o
);

  localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLK_DIV - 1);

  logic [1:0]  sync_q;
  logic        rx_prev_q;
  logic        rx_s;
  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;

  assign rx_s = sync_q[1];

  // Synchronizer resets to idle-high so no false start edge follows reset.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx};
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != 16'd0) ? cnt_q - 16'd1 : cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d = RX_START;
          cnt_d   = HALF_M1;
        end
      end
      RX_START: begin
        if (cnt_q == 16'd0) begin
          if (rx_s) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            cnt_d   = FULL_M1;
            bit_d   = 3'd0;
          end
        end
      end
      RX_DATA: begin
        if (cnt_q == 16'd0) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = FULL_M1;
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q == 16'd0) begin
          state_d = RX_IDLE;
          if (rx_s) valid_d = 1'b1;
          else      ferr_d  = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid  = valid_q;
  assign byte_data   = shift_q;
  assign framing_err = ferr_q;
  assign state_o     = state_q;

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: receives A5, 16-bit LE word count, then count LE 32-bit words over
// UART and writes them to instruction memory; holds the CPU in reset until done.
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT,
  parameter int          AW      = 11
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                rx,
  imem_uart_loader_if.master  imem,
  output logic                cpu_reset,
  output logic                done,
  output logic                err,
  output dbg_t                dbg_o
);

  localparam logic [16:0] MAX_WORDS = 17'(1) << AW;

  logic          byte_valid, framing_err;
  logic [7:0]    byte_data;
  rx_state_e     rx_state;

  loader_state_e state_q, state_d;
  logic [15:0]   count_q, count_d;
  logic [AW-1:0] word_q, word_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [31:0]   asm_q, asm_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          rearm;

  uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk_in      (clk_in),
    .reset       (reset),
    .rx          (rx),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .framing_err (framing_err),
    .state_o     (rx_state)
  );

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= ST_HDR;
      count_q <= '0;
      word_q  <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    word_d  = word_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rearm   = 1'b0;
    if (framing_err && state_q != ST_DONE) begin
      state_d = ST_ERR;
    end else if (byte_valid) begin
      case (state_q)
        ST_HDR: if (byte_data == HDR_BYTE) state_d = ST_CNT_LO;
        ST_CNT_LO: begin
          count_d[7:0] = byte_data;
          state_d      = ST_CNT_HI;
        end
        ST_CNT_HI: begin
          count_d = {byte_data, count_q[7:0]};
          word_d  = '0;
          bcnt_d  = '0;
          if (count_d == 16'd0 || {1'b0, count_d} > MAX_WORDS) state_d = ST_ERR;
          else                                                  state_d = ST_DATA;
        end
        ST_DATA: begin
          asm_d[{bcnt_q, 3'b000} +: 8] = byte_data;
          bcnt_d = bcnt_q + 2'd1;
          // Fourth byte: register the write; final word enters DONE alongside the strobe.
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = word_q;
            wdata_d = {byte_data, asm_q[23:0]};
            word_d  = word_q + 1'b1;
            if (16'(word_q) == count_q - 16'd1) state_d = ST_DONE;
          end
        end
        ST_DONE, ST_ERR: begin
          if (byte_data == HDR_BYTE) begin
            state_d = ST_CNT_LO;
            word_d  = '0;
            bcnt_d  = '0;
            rearm   = 1'b1;
          end
        end
        default: state_d = ST_HDR;
      endcase
    end
  end

  assign imem.imem_we    = we_q;
  assign imem.imem_addr  = addr_q;
  assign imem.imem_wdata = wdata_q;
  assign cpu_reset       = (state_q != ST_DONE) || rearm;
  assign done            = (state_q == ST_DONE);
  assign err             = (state_q == ST_ERR);
  assign dbg_o           = '{loader: state_q, rx: rx_state};

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: UART byte driver, frame-level reference model,
// write scoreboard with an expected queue and a monitor process.
module tb_imem_uart_loader;
  import imem_uart_loader_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int AW      = 11;

  logic clk_in;
  logic rst_n;
  logic rx;
  logic cpu_reset, done, err;
  dbg_t dbg;

  imem_uart_loader_if #(.AW(AW)) imem_bus ();

  imem_uart_loader #(.CLK_DIV(CLK_DIV), .AW(AW)) dut (
    .clk_in    (clk_in),
    .reset     (rst_n),
    .rx        (rx),
    .imem      (imem_bus),
    .cpu_reset (cpu_reset),
    .done      (done),
    .err       (err),
    .dbg_o     (dbg)
  );

  // ---------------- clock ----------------
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [AW+31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame protocol rules) ----------------
  // phase: 0 wait header, 1 count low, 2 count high, 3 payload, 4 done, 5 error
  int          m_phase;
  int          m_count;
  int          m_words;
  int          m_nbytes;
  logic [31:0] m_word;

  function automatic void model_reset();
    m_phase = 0; m_count = 0; m_words = 0; m_nbytes = 0; m_word = '0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    logic [AW-1:0] a;
    if (m_phase == 0) begin
      if (b == 8'hA5) m_phase = 1;
    end else if (m_phase == 1) begin
      m_count = int'(b);
      m_phase = 2;
    end else if (m_phase == 2) begin
      m_count = m_count + int'(b) * 256;
      m_words = 0; m_nbytes = 0;
      if (m_count == 0 || m_count > (1 << AW)) m_phase = 5;
      else                                      m_phase = 3;
    end else if (m_phase == 3) begin
      m_word = m_word >> 8;
      m_word[31:24] = b;
      m_nbytes++;
      if (m_nbytes == 4) begin
        a = AW'(m_words);
        exp_q.push_back({a, m_word});
        m_words++;
        m_nbytes = 0;
        if (m_words == m_count) m_phase = 4;
      end
    end else begin
      if (b == 8'hA5) begin
        m_phase = 1; m_words = 0; m_nbytes = 0;
      end
    end
  endfunction

  function automatic void model_ferr();
    if (m_phase != 4) m_phase = 5;
  endfunction

  // ---------------- monitor ----------------
  logic [AW-1:0] last_addr = '0;
  logic [31:0]   last_data = '0;

  always @(negedge clk_in) begin
    logic [AW+31:0] e;
    if (!rst_n) begin
      last_addr = '0;
      last_data = '0;
    end else if (imem_bus.imem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {imem_bus.imem_addr, imem_bus.imem_wdata}, '0);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 64'(imem_bus.imem_addr), 64'(e[AW+31:32]));
        check("write_data", 64'(imem_bus.imem_wdata), 64'(e[31:0]));
      end
      last_addr = imem_bus.imem_addr;
      last_data = imem_bus.imem_wdata;
    end else begin
      check("hold_addr_data", {imem_bus.imem_addr, imem_bus.imem_wdata}, {last_addr, last_data});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bit_out(input logic b);
    rx = b;
    repeat (CLK_DIV) @(negedge clk_in);
  endtask

  // nbits < 10 stops partway (start counts as bit 0) without touching the model.
  task automatic send_raw(input logic [7:0] b, input logic stop_bit, input int nbits);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < nbits; i++) bit_out(frame[i]);
    if (nbits == 10) begin
      rx = 1'b1;
      repeat (2 * CLK_DIV) @(negedge clk_in);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    send_raw(b, 1'b1, 10);
  endtask

  task automatic send_bad_stop(input logic [7:0] b);
    model_ferr();
    send_raw(b, 1'b0, 10);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_header(input int cnt);
    send_byte(8'hA5);
    send_byte(cnt[7:0]);
    send_byte(cnt[15:8]);
  endtask

  task automatic check_status(input string tag);
    repeat (4) @(negedge clk_in);
    check({tag, "_done"},      64'(done),      64'(m_phase == 4));
    check({tag, "_err"},       64'(err),       64'(m_phase == 5));
    check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(m_phase != 4));
    check({tag, "_pending"},   64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},        64'(imem_bus.imem_we),    64'd0);
    check({tag, "_addr"},      64'(imem_bus.imem_addr),  64'd0);
    check({tag, "_wdata"},     64'(imem_bus.imem_wdata), 64'd0);
    check({tag, "_cpu_reset"}, 64'(cpu_reset),           64'd1);
    check({tag, "_done"},      64'(done),                64'd0);
    check({tag, "_err"},       64'(err),                 64'd0);
    check({tag, "_state"},     64'(dbg.loader),          64'(ST_HDR));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk_in);
    model_reset();
    exp_q.delete();
    rst_n = 1'b1;
    repeat (3) @(negedge clk_in);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    rst_n = 1'b0;
    rx    = 1'b1;
    model_reset();
    repeat (3) @(negedge clk_in);
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (3) @(negedge clk_in);

    // Two-word directed frame.
    send_header(2);
    send_word(32'h2000_0013);
    send_word(32'h0000_0008);
    check_status("two_words");

    // Leading junk is ignored before the header.
    apply_reset();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_header(1);
    send_word(32'hDEAD_BEEF);
    check_status("junk_prefix");

    // Zero count and over-range count both error, then recover.
    send_header(0);
    check_status("count_zero");
    send_header(1);
    send_word(32'h1234_5678);
    check_status("recover_zero");
    send_header(16'h0801);
    check_status("count_over");
    send_header(1);
    send_word(32'h0BAD_F00D);
    check_status("recover_over");

    // Framing error on the second payload byte.
    apply_reset();
    send_header(2);
    send_byte(8'h11);
    send_bad_stop(8'h22);
    check_status("framing");

    // Reset asserted during the third byte of word 1.
    apply_reset();
    send_header(2);
    send_word(32'hCAFE_0001);
    send_byte(8'h33);
    send_byte(8'h44);
    send_raw(8'h55, 1'b1, 4);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    rx = 1'b1;
    repeat (3) @(negedge clk_in);
    model_reset();
    exp_q.delete();
    rst_n = 1'b1;
    repeat (3) @(negedge clk_in);
    send_header(2);
    send_word(32'h0101_0101);
    send_word(32'h8765_4321);
    check_status("after_reset");

    // Short low glitch while waiting for the count byte.
    send_byte(8'hA5);
    rx = 1'b0;
    @(negedge clk_in);
    rx = 1'b1;
    repeat (4 * CLK_DIV) @(negedge clk_in);
    check("glitch_state", 64'(dbg.loader), 64'(ST_CNT_LO));
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'h5A5A_0F0F);
    check_status("glitch");

    // Randomized frames re-armed from DONE/ERR.
    for (int f = 0; f < 8; f++) begin
      int njunk;
      njunk = $urandom_range(0, 2);
      for (int j = 0; j < njunk; j++) begin
        logic [7:0] jb;
        jb = 8'($urandom_range(0, 255));
        if (jb == 8'hA5) jb = 8'h5A;
        send_byte(jb);
      end
      cnt = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
      send_header(cnt);
      for (int w = 0; w < cnt; w++) send_word($urandom);
      check_status("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
